// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor family.
// Holds the controller state encoding used by serial_subtractor.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// One-bit full subtractor: d = a - b - bin, bout = borrow out.
// Purely combinational so it can be tiled into a parallel subtractor later.
module fs_cell (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor, LSB first: diff = in1 - in2 as an N+1 bit result.
// Start/done handshake; one bit per clock, result registered on the last bit.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] in1,
   input  logic [N-1:0] in2,
   output logic         busy,
   output logic         done,
   output logic [N:0]   diff
);

   localparam int CNT_W = $clog2(N + 1);

   state_t             state_reg;
   logic [N-1:0]       a_reg;
   logic [N-1:0]       b_reg;
   logic [N-1:0]       res_reg;
   logic               borrow_reg;
   logic [CNT_W-1:0]   cnt_reg;
   logic               busy_reg;
   logic               done_reg;
   logic [N:0]         diff_reg;

   logic               bit_d;
   logic               borrow_next;

   fs_cell u_fs_cell (
      .a    (a_reg[0]),
      .b    (b_reg[0]),
      .bin  (borrow_reg),
      .d    (bit_d),
      .bout (borrow_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         a_reg      <= '0;
         b_reg      <= '0;
         res_reg    <= '0;
         borrow_reg <= 1'b0;
         cnt_reg    <= '0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
         diff_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               done_reg <= 1'b0;
               busy_reg <= start;
               if (start) begin
                  a_reg      <= in1;
                  b_reg      <= in2;
                  borrow_reg <= 1'b0;
                  cnt_reg    <= '0;
                  state_reg  <= SHIFT;
               end
            end
            SHIFT: begin
               // Result fills from the MSB side so bit 0 lands at res_reg[0] after N shifts.
               res_reg    <= {bit_d, res_reg[N-1:1]};
               a_reg      <= {1'b0, a_reg[N-1:1]};
               b_reg      <= {1'b0, b_reg[N-1:1]};
               borrow_reg <= borrow_next;
               cnt_reg    <= cnt_reg + CNT_W'(1);
               if (cnt_reg == CNT_W'(N - 1)) begin
                  diff_reg  <= {borrow_next, bit_d, res_reg[N-1:1]};
                  done_reg  <= 1'b1;
                  state_reg <= DONE;
               end
            end
            DONE: begin
               done_reg  <= 1'b0;
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: begin
               done_reg  <= 1'b0;
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign busy = busy_reg;
   assign done = done_reg;
   assign diff = diff_reg;

endmodule
